// File: rtl/pc_fetch_unit.sv
// Program counter and next-address selection for the single-cycle MIPS core.
// PC[31] doubles as the kernel-mode flag; irq/exception vectoring lives here.
module pc_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        undef_op,
    input  logic        irq,
    output logic        squash,
    output logic        xp_wr,
    output logic [31:0] xp_addr,
    output logic        kernel,
    output logic [31:0] instret
);

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

    logic        irq_pending;
    logic        irq_take;
    logic        exc_take;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_dest;
    logic [31:0] next_pc;

    assign pc_plus4 = pc + 32'd4;
    assign kernel   = pc[31];

    // An exception in the same cycle defers the interrupt; it stays pending.
    assign exc_take = undef_op;
    assign irq_take = irq_pending && !pc[31] && !undef_op;

    assign squash  = irq_take || exc_take;
    assign xp_wr   = squash;
    assign xp_addr = irq_take ? pc : pc_plus4;

    assign br_target = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign j_target  = {pc_plus4[31:28], jump_idx, 2'b00};
    // Only kernel code may keep bit 31 set across a register jump.
    assign jr_dest   = {jr_target[31] & pc[31], jr_target[30:0]};

    always_comb begin
        next_pc = pc_plus4;
        if (exc_take)          next_pc = EXC_VEC;
        else if (irq_take)     next_pc = IRQ_VEC;
        else if (jr)           next_pc = jr_dest;
        else if (jump)         next_pc = j_target;
        else if (branch_taken) next_pc = br_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_VEC;
            irq_pending <= 1'b0;
            instret     <= 32'd0;
        end else begin
            pc          <= next_pc;
            irq_pending <= irq || (irq_pending && !irq_take);
            if (!squash) instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, pc_plus4, xp_addr, instret;
    logic        branch_taken, jump, jr, undef_op, irq;
    logic [15:0] branch_imm;
    logic [25:0] jump_idx;
    logic [31:0] jr_target;
    logic        squash, xp_wr, kernel;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        logic        sq;
        logic [31:0] xa;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_plus4(pc_plus4),
        .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jump(jump), .jump_idx(jump_idx), .jr(jr), .jr_target(jr_target),
        .undef_op(undef_op), .irq(irq), .squash(squash), .xp_wr(xp_wr),
        .xp_addr(xp_addr), .kernel(kernel), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
            chk("kernel", {31'd0, kernel}, {31'd0, e.pc[31]});
            chk("instret", instret, e.instret);
            chk("squash", {31'd0, squash}, {31'd0, e.sq});
            chk("xp_wr", {31'd0, xp_wr}, {31'd0, e.sq});
            chk("xp_addr", xp_addr, e.xa);
        end
    end

    // Non-squash cycles always report pc+4 as the return address.
    task automatic expect_cyc(input logic [31:0] epc, input logic [31:0] eret,
                              input logic esq, input logic [31:0] exa);
        exp_t e;
        e.pc = epc; e.instret = eret; e.sq = esq;
        e.xa = esq ? exa : epc + 32'd4;
        q.push_back(e);
    endtask

    task automatic clr();
        reset = 0; branch_taken = 0; branch_imm = '0; jump = 0;
        jump_idx = '0; jr = 0; jr_target = '0; undef_op = 0; irq = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1; clr();
    endtask

    initial begin
        clr();
        reset = 1;
        repeat (2) @(posedge clk);
        #1; clr();
        // C0..C2 free run, irq in kernel during C2, reset in C3
        expect_cyc(32'h8000_0000, 0, 0, 0); tick();
        expect_cyc(32'h8000_0004, 1, 0, 0); tick();
        irq = 1;
        expect_cyc(32'h8000_0008, 2, 0, 0); tick();
        reset = 1;
        expect_cyc(32'h8000_000C, 3, 0, 0); tick();
        // C4 jump idx 14 -> 0x8000_0038
        jump = 1; jump_idx = 26'd14;
        expect_cyc(32'h8000_0000, 0, 0, 0); tick();
        jr = 1; jr_target = 32'h0000_0010;
        expect_cyc(32'h8000_0038, 1, 0, 0); tick();
        branch_taken = 1; branch_imm = 16'hFFFD;
        expect_cyc(32'h0000_0010, 2, 0, 0); tick();
        expect_cyc(32'h0000_0008, 3, 0, 0); tick();
        expect_cyc(32'h0000_000C, 4, 0, 0); tick();
        branch_taken = 1; branch_imm = 16'h0003;
        expect_cyc(32'h0000_0010, 5, 0, 0); tick();
        jr = 1; jr_target = 32'h0000_0100;
        expect_cyc(32'h0000_0020, 6, 0, 0); tick();
        // user jr cannot set bit 31
        jr = 1; jr_target = 32'h8000_0000;
        expect_cyc(32'h0000_0100, 7, 0, 0); tick();
        jump = 1; jump_idx = 26'h0F;
        expect_cyc(32'h0000_0000, 8, 0, 0); tick();
        irq = 1;
        expect_cyc(32'h0000_003C, 9, 0, 0); tick();
        expect_cyc(32'h0000_0040, 10, 1, 32'h0000_0040); tick();
        jump = 1; jump_idx = 26'h14;
        expect_cyc(32'h8000_0004, 10, 0, 0); tick();
        irq = 1;
        expect_cyc(32'h8000_0050, 11, 0, 0); tick();
        jr = 1; jr_target = 32'h0000_0060;
        expect_cyc(32'h8000_0054, 12, 0, 0); tick();
        branch_taken = 1; jump = 1; jr = 1; jr_target = 32'h0000_0999;
        expect_cyc(32'h0000_0060, 13, 1, 32'h0000_0060); tick();
        irq = 1; jr = 1; jr_target = 32'h0000_0070;
        expect_cyc(32'h8000_0004, 13, 0, 0); tick();
        undef_op = 1;
        expect_cyc(32'h0000_0070, 14, 1, 32'h0000_0074); tick();
        jr = 1; jr_target = 32'h0000_0074;
        expect_cyc(32'h8000_0008, 14, 0, 0); tick();
        expect_cyc(32'h0000_0074, 15, 1, 32'h0000_0074); tick();
        jr = 1; jr_target = 32'h8000_0200;
        expect_cyc(32'h8000_0004, 15, 0, 0); tick();
        jr = 1; jr_target = 32'h0000_1000;
        expect_cyc(32'h8000_0200, 16, 0, 0); tick();
        jr = 1; jr_target = 32'h8000_0300;
        expect_cyc(32'h0000_1000, 17, 0, 0); tick();
        undef_op = 1; jump = 1; jump_idx = 26'h3;
        expect_cyc(32'h0000_0300, 18, 1, 32'h0000_0304); tick();
        expect_cyc(32'h8000_0008, 18, 0, 0); tick();
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and next-address stage that drives the instruction memory address bus of the single-cycle MIPS core. Holds the PC and a kernel-mode flag in PC[31], and selects the next PC from sequential, branch, jump, jump-register, interrupt, exception and reset sources. Latches timer interrupt requests until they are taken, squashes the instruction being preempted, and supplies the return address written to $k0 ($26). Also keeps a retired-instruction counter.

## Interface
- RESET_VEC, 32'h8000_0000, PC loaded on reset (ROM word 0)
- IRQ_VEC, 32'h8000_0004, interrupt entry (ROM word 1)
- EXC_VEC, 32'h8000_0008, exception entry (ROM word 2)

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- pc  out  32  current PC, driven to instruction memory Address
- pc_plus4  out  32  pc + 4, for link and return values
- branch_taken  in  1  conditional branch resolved taken this cycle
- branch_imm  in  16  branch offset in words, sign-extended
- jump  in  1  j/jal this cycle
- jump_idx  in  26  jump target word index
- jr  in  1  jr/jalr this cycle
- jr_target  in  32  register value for jr
- undef_op  in  1  decoder flags an undefined instruction
- irq  in  1  timer interrupt request, level or single-cycle pulse
- squash  out  1  comb.; current instruction must not write regfile or memory
- xp_wr  out  1  comb.; write xp_addr to $26 this cycle
- xp_addr  out  32  return address for $26
- kernel  out  1  equals pc[31]
- instret  out  32  count of retired (non-squashed) instructions

## Operation
- Next-PC priority, highest first: reset -> RESET_VEC; undef_op -> EXC_VEC; irq_pending && !pc[31] -> IRQ_VEC; jr; jump; branch_taken; pc+4.
- Branch target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00}, 32-bit modulo arithmetic.
- Jump target = {pc_plus4[31:28], jump_idx, 2'b00}.
- JR target = {jr_target[31] & pc[31], jr_target[30:0]}. User mode can never set bit 31. Kernel jr to an address with bit 31 clear returns to user mode.
- irq_pending register: set on any cycle with irq=1; cleared only in the cycle the interrupt is taken. Stays pending while in kernel mode. An interrupt is taken on the first user-mode cycle in which it is pending.
- Interrupt taken: squash=1, xp_wr=1, xp_addr=pc. The preempted instruction is re-executed on return.
- Exception taken: squash=1, xp_wr=1, xp_addr=pc_plus4. The faulting instruction is skipped on return. Exceptions are taken in either mode.
- undef_op and a pending irq in the same cycle: exception wins and irq stays pending.
- When squash=1, branch_taken, jump and jr are ignored.
- Outside the interrupt/exception cases, xp_wr=0, squash=0 and xp_addr=pc_plus4.
- instret increments by 1 on each posedge with squash=0 and reset=0, and wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values: pc=RESET_VEC, irq_pending=0, instret=0. After reset, kernel=1 and squash=0.
- reset asserted mid-program: pc=RESET_VEC at the next edge. A pending irq is discarded and instret is cleared.
- squash, xp_wr, xp_addr and pc_plus4 are combinational from pc, irq_pending and undef_op in the same cycle.
- irq sampled at edge N: the earliest vectoring is the cycle after edge N, with PC=IRQ_VEC after edge N+1.
- A one-cycle irq pulse must not be lost, including when it arrives in kernel mode.
- Every redirect has zero bubbles: the new pc is valid one edge after its request.

## Test plan
- Reset, then free-run 3 cycles -> pc 0x8000_0000, 0x8000_0004, 0x8000_0008; instret=3.
- At pc=0x0000_0010, branch_taken with imm=16'hFFFD -> next pc=0x0000_0008. Repeat with imm=16'h0003 -> next pc=0x0000_0020.
- At pc=0x8000_0000, jump with jump_idx=14 -> pc=0x8000_0038. At pc=0x0000_0100, jr with jr_target=0x8000_0000 -> pc=0x0000_0000.
- User pc=0x0000_0040, one-cycle irq pulse -> next cycle squash=1, xp_wr=1, xp_addr=0x0000_0040, then pc=0x8000_0004. The instret increment is skipped for the squashed cycle.
- irq pulse while pc=0x8000_0050 (kernel) -> no vectoring. After a kernel jr to 0x0000_0060, the next cycle vectors with xp_addr=0x0000_0060.
- undef_op and pending irq together at pc=0x0000_0070 -> pc=0x8000_0008, xp_addr=0x0000_0074. The irq is still pending after the handler jr back to user mode.
